// File: rtl/alu_reservation_station.sv
// ALU reservation station: holds dispatched ops until both operands resolve, snoops both CDBs, issues one per cycle.
// Optional RS_CDB_BYPASS_EN: an entry completed by a same-cycle CDB broadcast may issue on that edge.
module alu_reservation_station #(
  parameter int RS_SIZE = 16,
  parameter int ROB_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             clr,
  input  logic             DP_sgn,
  input  logic [5:0]       DP_opcode,
  input  logic [ROB_W-1:0] DP_ROB_name,
  input  logic [31:0]      DP_Vj,
  input  logic [31:0]      DP_Vk,
  input  logic [ROB_W-1:0] DP_Qj,
  input  logic [ROB_W-1:0] DP_Qk,
  input  logic             DP_Rj,
  input  logic             DP_Rk,
  output logic             full,
  output logic             ALU_sgn,
  output logic [5:0]       ALU_opcode,
  output logic [ROB_W-1:0] ALU_ROB_name,
  output logic [31:0]      ALU_lhs,
  output logic [31:0]      ALU_rhs,
  input  logic             CDBA_sgn,
  input  logic [31:0]      CDBA_result,
  input  logic [ROB_W-1:0] CDBA_ROB_name,
  input  logic             CDBL_sgn,
  input  logic [31:0]      CDBL_result,
  input  logic [ROB_W-1:0] CDBL_ROB_name
);
  localparam int IDX_W = $clog2(RS_SIZE);

  logic [RS_SIZE-1:0] busy, rj, rk;
  logic [5:0]         op_q  [RS_SIZE];
  logic [ROB_W-1:0]   rob_q [RS_SIZE];
  logic [ROB_W-1:0]   qj_q  [RS_SIZE];
  logic [ROB_W-1:0]   qk_q  [RS_SIZE];
  logic [31:0]        vj_q  [RS_SIZE];
  logic [31:0]        vk_q  [RS_SIZE];

  logic [RS_SIZE-1:0] hit_aj, hit_lj, hit_ak, hit_lk, elig, busy_next;
  logic               free_found, issue_found, dp_take;
  logic [IDX_W-1:0]   free_idx, issue_idx;
  logic [31:0]        lhs_sel, rhs_sel;
  logic               dp_aj, dp_lj, dp_ak, dp_lk;

  always_comb begin
    hit_aj = '0;
    hit_lj = '0;
    hit_ak = '0;
    hit_lk = '0;
    elig   = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      hit_aj[i] = CDBA_sgn && (CDBA_ROB_name == qj_q[i]);
      hit_lj[i] = CDBL_sgn && (CDBL_ROB_name == qj_q[i]);
      hit_ak[i] = CDBA_sgn && (CDBA_ROB_name == qk_q[i]);
      hit_lk[i] = CDBL_sgn && (CDBL_ROB_name == qk_q[i]);
`ifdef RS_CDB_BYPASS_EN
      elig[i] = busy[i] && (rj[i] || hit_aj[i] || hit_lj[i])
                        && (rk[i] || hit_ak[i] || hit_lk[i]);
`else
      elig[i] = busy[i] && rj[i] && rk[i];
`endif
    end
  end

  // Downward scans leave the lowest matching index in the result.
  always_comb begin
    free_found  = 1'b0;
    free_idx    = '0;
    issue_found = 1'b0;
    issue_idx   = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!busy[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
      if (elig[i]) begin
        issue_found = 1'b1;
        issue_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    lhs_sel = vj_q[issue_idx];
    rhs_sel = vk_q[issue_idx];
`ifdef RS_CDB_BYPASS_EN
    if (!rj[issue_idx]) lhs_sel = hit_aj[issue_idx] ? CDBA_result : CDBL_result;
    if (!rk[issue_idx]) rhs_sel = hit_ak[issue_idx] ? CDBA_result : CDBL_result;
`endif
  end

  assign dp_take = DP_sgn && !full && free_found;
  assign dp_aj   = CDBA_sgn && (CDBA_ROB_name == DP_Qj);
  assign dp_lj   = CDBL_sgn && (CDBL_ROB_name == DP_Qj);
  assign dp_ak   = CDBA_sgn && (CDBA_ROB_name == DP_Qk);
  assign dp_lk   = CDBL_sgn && (CDBL_ROB_name == DP_Qk);

  // Dispatch targets a slot that was free at the start of the cycle, never the one being issued.
  always_comb begin
    busy_next = busy;
    if (issue_found) busy_next[issue_idx] = 1'b0;
    if (dp_take)     busy_next[free_idx]  = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy         <= '0;
      rj           <= '0;
      rk           <= '0;
      full         <= 1'b0;
      ALU_sgn      <= 1'b0;
      ALU_opcode   <= '0;
      ALU_ROB_name <= '0;
      ALU_lhs      <= '0;
      ALU_rhs      <= '0;
      for (int i = 0; i < RS_SIZE; i++) begin
        op_q[i]  <= '0;
        rob_q[i] <= '0;
        qj_q[i]  <= '0;
        qk_q[i]  <= '0;
        vj_q[i]  <= '0;
        vk_q[i]  <= '0;
      end
    end else if (clr) begin
      busy    <= '0;
      full    <= 1'b0;
      ALU_sgn <= 1'b0;
    end else if (!rdy) begin
      ALU_sgn <= 1'b0;
    end else begin
      for (int i = 0; i < RS_SIZE; i++) begin
        if (busy[i] && !rj[i]) begin
          if (hit_aj[i]) begin
            vj_q[i] <= CDBA_result;
            rj[i]   <= 1'b1;
          end else if (hit_lj[i]) begin
            vj_q[i] <= CDBL_result;
            rj[i]   <= 1'b1;
          end
        end
        if (busy[i] && !rk[i]) begin
          if (hit_ak[i]) begin
            vk_q[i] <= CDBA_result;
            rk[i]   <= 1'b1;
          end else if (hit_lk[i]) begin
            vk_q[i] <= CDBL_result;
            rk[i]   <= 1'b1;
          end
        end
      end

      ALU_sgn <= issue_found;
      if (issue_found) begin
        ALU_opcode   <= op_q[issue_idx];
        ALU_ROB_name <= rob_q[issue_idx];
        ALU_lhs      <= lhs_sel;
        ALU_rhs      <= rhs_sel;
      end

      if (dp_take) begin
        op_q[free_idx]  <= DP_opcode;
        rob_q[free_idx] <= DP_ROB_name;
        qj_q[free_idx]  <= DP_Qj;
        qk_q[free_idx]  <= DP_Qk;
        if (DP_Rj) begin
          vj_q[free_idx] <= DP_Vj;
          rj[free_idx]   <= 1'b1;
        end else if (dp_aj) begin
          vj_q[free_idx] <= CDBA_result;
          rj[free_idx]   <= 1'b1;
        end else if (dp_lj) begin
          vj_q[free_idx] <= CDBL_result;
          rj[free_idx]   <= 1'b1;
        end else begin
          vj_q[free_idx] <= DP_Vj;
          rj[free_idx]   <= 1'b0;
        end
        if (DP_Rk) begin
          vk_q[free_idx] <= DP_Vk;
          rk[free_idx]   <= 1'b1;
        end else if (dp_ak) begin
          vk_q[free_idx] <= CDBA_result;
          rk[free_idx]   <= 1'b1;
        end else if (dp_lk) begin
          vk_q[free_idx] <= CDBL_result;
          rk[free_idx]   <= 1'b1;
        end else begin
          vk_q[free_idx] <= DP_Vk;
          rk[free_idx]   <= 1'b0;
        end
      end

      busy <= busy_next;
      full <= &busy_next;
    end
  end
endmodule
